sdram_block_copier: RTL and testbench
=====================================

Name: sdram_block_copier

Overview:
Avalon-MM master that copies a block of words from one SDRAM region to another. The HPS starts it through the start/done PIO conduit pair. Transfers run in chunks: up to BUF_DEPTH pipelined reads fill an internal FIFO, then the FIFO drains as writes, and the cycle repeats until the block is done. A running 32-bit checksum of the copied words is exposed so software can verify the copy.

Parameters:
ADDR_W, 32, Avalon byte-address width
DATA_W, 16, data width; matches the SDRAM controller port
BUF_DEPTH, 16, words per chunk / FIFO depth; must be a power of 2 and ≥2
CNT_W, 24, width of the word-count input

Ports:
clk  in  1  system clock (clk_clk domain)
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle request pulse from the HPS PIO
src_addr  in  ADDR_W  source byte address; latched on an accepted start
dst_addr  in  ADDR_W  destination byte address; latched on an accepted start
word_count  in  CNT_W  number of DATA_W words to copy; latched on an accepted start
busy  out  1  high from the cycle after an accepted start until DONE
done  out  1  level; high once the copy completes, cleared by the next accepted start
checksum  out  32  sum mod 2^32 of all words read in the current job
avm_address  out  ADDR_W  Avalon address
avm_read  out  1  Avalon read request
avm_write  out  1  Avalon write request
avm_writedata  out  DATA_W  write data
avm_byteenable  out  DATA_W/8  always all ones
avm_waitrequest  in  1  slave stall
avm_readdata  in  DATA_W  read data
avm_readdatavalid  in  1  read data strobe; pipelined reads with variable latency

Behaviour:
- Reset values: busy=0, done=0, checksum=0, avm_read=0, avm_write=0, avm_address=0, avm_writedata=0; FSM in IDLE; FIFO empty; all counters 0.
- FSM states: IDLE, RD_ISSUE, RD_WAIT, WR, DONE.
- IDLE, start=1: latch src, dst and count; clear done and checksum. If count=0 go to DONE, otherwise go to RD_ISSUE with chunk=min(remaining, BUF_DEPTH). avm_read is asserted in the cycle after start.
- start is ignored in every state except IDLE and DONE.
- RD_ISSUE:
  - avm_read=1 and avm_address=src_ptr.
  - A read is accepted when avm_read & !avm_waitrequest. On accept, src_ptr += DATA_W/8 and issued++.
  - When issued reaches chunk, avm_read drops in the next cycle and the FSM goes to RD_WAIT.
  - avm_address and avm_read stay stable while waitrequest is high.
- readdatavalid handling, in RD_ISSUE or RD_WAIT: push readdata into the FIFO, checksum += zero-extended readdata, received++.
- RD_WAIT: when received == chunk, go to WR. A transition is allowed in the same cycle as the final readdatavalid.
- WR:
  - avm_write=1, avm_address=dst_ptr, avm_writedata=FIFO head.
  - On accept (write & !waitrequest): pop the FIFO and dst_ptr += DATA_W/8.
  - When the last word of the chunk is accepted: remaining -= chunk. If remaining=0 go to DONE, otherwise go to RD_ISSUE with a new chunk and issued/received cleared.
  - Reads and writes are never asserted in the same cycle.
- DONE: done=1 and busy=0. Stay here until start=1, which behaves exactly like start in IDLE.
- Address arithmetic wraps modulo 2^ADDR_W with no error.
- A final partial chunk (remaining < BUF_DEPTH) issues exactly `remaining` reads.
- FIFO never overflows because issued ≤ BUF_DEPTH per chunk. FIFO empty in WR cannot occur by construction; an assertion guards it.
- readdatavalid in IDLE or DONE, e.g. stale data after reset, is ignored. The FIFO and checksum are not modified.
- Reset mid-transfer: the FSM returns to IDLE immediately and asynchronously, and all outputs go to their reset values. There is no completion and no done.

Decomposition:
- Package sdram_copier_pkg holds:
  - the state enum;
  - the byte-stride constant DATA_W/8;
  - the chunk-size function min(remaining, BUF_DEPTH).
- Sub-module sdram_copier_fifo: synchronous FIFO, BUF_DEPTH×DATA_W, with push, pop, head, empty and full; async active-high reset clears its pointers.

Test Plan:
- src=0x1000, dst=0x8000, count=4, zero-wait slave with 2-cycle read latency. Expect: 4 reads at 0x1000/02/04/06, then 4 writes at 0x8000..0x8006 with identical data; done=1; checksum equals the sum of the 4 words.
- count=0 → done=1 two cycles after start; no avm_read or avm_write ever asserted; checksum=0.
- count=37, BUF_DEPTH=16 → chunks of 16, 16 and 5. Expect 37 reads and 37 writes, never more than 16 outstanding reads, and the destination matches the source.
- Random waitrequest at 50% and read latency 1–8 cycles. Expect address and request stable while stalled, data correct, and a correct checksum including 16-bit carry into the upper bits (words 0xFFFF×3 → 0x0002FFFD).
- start pulsed again while busy → ignored, transfer unaffected. Second start while in DONE → done drops the next cycle and a new job runs.
- reset asserted during WR of a count=20 job, with a late readdatavalid after release. Expect: outputs zero immediately, FSM in IDLE, stale data ignored, and a subsequent count=2 job completes correctly.

Source files
------------

// File: rtl/sdram_copier_pkg.sv
// -----------------------------------------------------------------------------
// sdram_copier_pkg
// Shared definitions for the SDRAM block copier:
//   state_e       - copier FSM states
//   BYTE_STRIDE   - byte stride for the default 16-bit data path
//   byte_stride() - byte stride for an arbitrary data width
//   chunk_len()   - words in the next chunk, min(remaining, depth)
// -----------------------------------------------------------------------------
package sdram_copier_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_RD_ISSUE = 3'd1,
      ST_RD_WAIT  = 3'd2,
      ST_WR       = 3'd3,
      ST_DONE     = 3'd4
   } state_e;

   localparam int unsigned DEF_DATA_W  = 16;
   localparam int unsigned BYTE_STRIDE = DEF_DATA_W / 8;

   function automatic int unsigned byte_stride(input int unsigned data_w);
      return data_w / 8;
   endfunction

   function automatic int unsigned chunk_len(input int unsigned remaining,
                                             input int unsigned depth);
      return (remaining < depth) ? remaining : depth;
   endfunction

endpackage

// File: rtl/sdram_copier_fifo.sv
// -----------------------------------------------------------------------------
// sdram_copier_fifo
// Synchronous show-ahead FIFO holding one chunk of read data.
//   clk, rst   - clock, asynchronous active-high reset (clears pointers)
//   push       - write push_data at the tail
//   pop        - discard the head word
//   head       - current head word (valid when !empty)
//   empty/full - occupancy flags
// -----------------------------------------------------------------------------
module sdram_copier_fifo #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             empty,
   output logic             full
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;

   // Extra pointer MSB distinguishes full from empty when the indices match.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
   end

   assign head  = mem_q[rd_ptr_q[AW-1:0]];
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/sdram_block_copier.sv
// -----------------------------------------------------------------------------
// sdram_block_copier
// Avalon-MM master copying word_count DATA_W words from src_addr to dst_addr
// in chunks of up to BUF_DEPTH words (pipelined reads into a FIFO, then writes).
//   clk, reset        - clock, asynchronous active-high reset
//   start             - one-cycle job request (accepted in IDLE or DONE)
//   src_addr/dst_addr - byte addresses, latched on an accepted start
//   word_count        - words to copy, latched on an accepted start
//   busy / done       - job in progress / job complete (level)
//   checksum          - mod 2^32 sum of all words read in the current job
//   avm_*             - Avalon-MM master port
// -----------------------------------------------------------------------------
module sdram_block_copier #(
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned DATA_W    = 16,
   parameter int unsigned BUF_DEPTH = 16,
   parameter int unsigned CNT_W     = 24
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [ADDR_W-1:0]   src_addr,
   input  logic [ADDR_W-1:0]   dst_addr,
   input  logic [CNT_W-1:0]    word_count,
   output logic                busy,
   output logic                done,
   output logic [31:0]         checksum,
   output logic [ADDR_W-1:0]   avm_address,
   output logic                avm_read,
   output logic                avm_write,
   output logic [DATA_W-1:0]   avm_writedata,
   output logic [DATA_W/8-1:0] avm_byteenable,
   input  logic                avm_waitrequest,
   input  logic [DATA_W-1:0]   avm_readdata,
   input  logic                avm_readdatavalid
);

   import sdram_copier_pkg::*;

   localparam int unsigned       CW     = $clog2(BUF_DEPTH) + 1;
   localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(byte_stride(DATA_W));

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   src_ptr_q, src_ptr_d;
   logic [ADDR_W-1:0]   dst_ptr_q, dst_ptr_d;
   logic [CNT_W-1:0]    remaining_q, remaining_d;
   logic [CW-1:0]       chunk_q, chunk_d;
   logic [CW-1:0]       issued_q, issued_d;
   logic [CW-1:0]       received_q, received_d;
   logic [CW-1:0]       written_q, written_d;
   logic [31:0]         checksum_q, checksum_d;
   logic [CNT_W-1:0]    rem_after;

   logic                rd_acc, wr_acc, fifo_push;
   logic [DATA_W-1:0]   fifo_head;
   logic                fifo_empty, fifo_full;

   assign rd_acc    = (state_q == ST_RD_ISSUE) && !avm_waitrequest;
   assign wr_acc    = (state_q == ST_WR) && !avm_waitrequest;
   // Read data is only meaningful while a chunk is being fetched; anything
   // arriving in IDLE/DONE (e.g. responses to reads cut off by reset) is dropped.
   assign fifo_push = avm_readdatavalid &&
                      ((state_q == ST_RD_ISSUE) || (state_q == ST_RD_WAIT));

   sdram_copier_fifo #(
      .DEPTH (BUF_DEPTH),
      .WIDTH (DATA_W)
   ) u_fifo (
      .clk       (clk),
      .rst       (reset),
      .push      (fifo_push),
      .push_data (avm_readdata),
      .pop       (wr_acc),
      .head      (fifo_head),
      .empty     (fifo_empty),
      .full      (fifo_full)
   );

   always_comb begin
      state_d     = state_q;
      src_ptr_d   = src_ptr_q;
      dst_ptr_d   = dst_ptr_q;
      remaining_d = remaining_q;
      chunk_d     = chunk_q;
      issued_d    = issued_q;
      received_d  = received_q;
      written_d   = written_q;
      checksum_d  = checksum_q;
      rem_after   = remaining_q - CNT_W'(chunk_q);

      if (fifo_push) begin
         checksum_d = checksum_q + 32'(avm_readdata);
         received_d = received_q + CW'(1);
      end

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               src_ptr_d   = src_addr;
               dst_ptr_d   = dst_addr;
               remaining_d = word_count;
               chunk_d     = CW'(chunk_len(32'(word_count), BUF_DEPTH));
               issued_d    = '0;
               received_d  = '0;
               written_d   = '0;
               checksum_d  = '0;
               state_d     = (word_count == '0) ? ST_DONE : ST_RD_ISSUE;
            end
         end
         ST_RD_ISSUE: begin
            if (rd_acc) begin
               src_ptr_d = src_ptr_q + STRIDE;
               issued_d  = issued_q + CW'(1);
               if (issued_q + CW'(1) == chunk_q) state_d = ST_RD_WAIT;
            end
         end
         ST_RD_WAIT: begin
            if (received_d == chunk_q) state_d = ST_WR;
         end
         ST_WR: begin
            if (wr_acc) begin
               dst_ptr_d = dst_ptr_q + STRIDE;
               written_d = written_q + CW'(1);
               if (written_q + CW'(1) == chunk_q) begin
                  remaining_d = rem_after;
                  chunk_d     = CW'(chunk_len(32'(rem_after), BUF_DEPTH));
                  issued_d    = '0;
                  received_d  = '0;
                  written_d   = '0;
                  state_d     = (rem_after == '0) ? ST_DONE : ST_RD_ISSUE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         src_ptr_q   <= '0;
         dst_ptr_q   <= '0;
         remaining_q <= '0;
         chunk_q     <= '0;
         issued_q    <= '0;
         received_q  <= '0;
         written_q   <= '0;
         checksum_q  <= '0;
      end else begin
         state_q     <= state_d;
         src_ptr_q   <= src_ptr_d;
         dst_ptr_q   <= dst_ptr_d;
         remaining_q <= remaining_d;
         chunk_q     <= chunk_d;
         issued_q    <= issued_d;
         received_q  <= received_d;
         written_q   <= written_d;
         checksum_q  <= checksum_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         if (state_q == ST_WR) assert (!fifo_empty);
         if (fifo_push)        assert (!fifo_full);
      end
   end

   // Bus outputs decode straight from registered state, so they hold steady
   // under waitrequest and fall to zero the instant reset is asserted.
   assign avm_read       = (state_q == ST_RD_ISSUE);
   assign avm_write      = (state_q == ST_WR);
   assign avm_address    = avm_read  ? src_ptr_q :
                           avm_write ? dst_ptr_q : '0;
   assign avm_writedata  = avm_write ? fifo_head : '0;
   assign avm_byteenable = '1;
   assign busy           = (state_q == ST_RD_ISSUE) || (state_q == ST_RD_WAIT) ||
                           (state_q == ST_WR);
   assign done           = (state_q == ST_DONE);
   assign checksum       = checksum_q;

endmodule

// File: tb/tb_sdram_block_copier.sv
module tb_sdram_block_copier;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [31:0] src_addr = '0;
   logic [31:0] dst_addr = '0;
   logic [23:0] word_count = '0;
   logic        busy, done;
   logic [31:0] checksum;
   logic [31:0] avm_address;
   logic        avm_read, avm_write;
   logic [15:0] avm_writedata;
   logic [1:0]  avm_byteenable;
   logic        avm_waitrequest = 1'b0;
   logic [15:0] avm_readdata = '0;
   logic        avm_readdatavalid = 1'b0;

   always #5 clk = ~clk;

   sdram_block_copier #(
      .ADDR_W    (32),
      .DATA_W    (16),
      .BUF_DEPTH (16),
      .CNT_W     (24)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .start             (start),
      .src_addr          (src_addr),
      .dst_addr          (dst_addr),
      .word_count        (word_count),
      .busy              (busy),
      .done              (done),
      .checksum          (checksum),
      .avm_address       (avm_address),
      .avm_read          (avm_read),
      .avm_write         (avm_write),
      .avm_writedata     (avm_writedata),
      .avm_byteenable    (avm_byteenable),
      .avm_waitrequest   (avm_waitrequest),
      .avm_readdata      (avm_readdata),
      .avm_readdatavalid (avm_readdatavalid)
   );

   typedef struct { logic [31:0] addr; logic [15:0] data; } wr_t;
   typedef struct { logic [15:0] data; int unsigned due; } rsp_t;

   int unsigned tests = 0;
   int unsigned fails = 0;

   logic [15:0] mem [logic [31:0]];
   logic [31:0] exp_rd_q [$];
   wr_t         exp_wr_q [$];
   logic [31:0] exp_ck_q [$];
   rsp_t        rsp_q    [$];

   bit          rand_wait = 1'b0;
   int unsigned lat_min = 2, lat_max = 2;
   bit          stale_inject = 1'b0;
   int unsigned cyc = 0, outstanding = 0, last_due = 0;
   bit          prev_rd_stall = 1'b0, prev_wr_stall = 1'b0;
   logic [31:0] prev_addr = '0;
   logic [15:0] prev_data = '0;
   logic        done_prev = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic flag(input string name, input logic [31:0] act);
      tests++;
      fails++;
      $display("FAIL %s: got 0x%08h expected no such event", name, act);
   endtask

   // Slave + monitor: inputs for the next edge are chosen here, handshakes
   // for that edge are scored here (DUT outputs are stable between edges).
   always @(negedge clk) begin
      wr_t         ew;
      rsp_t        r;
      logic        wreq;
      int unsigned due;
      cyc++;
      if (reset) begin
         rsp_q.delete();
         outstanding       = 0;
         last_due          = 0;
         avm_waitrequest   = 1'b0;
         avm_readdatavalid = 1'b0;
         avm_readdata      = '0;
         prev_rd_stall     = 1'b0;
         prev_wr_stall     = 1'b0;
         done_prev         = 1'b0;
      end else begin
         if (prev_rd_stall) begin
            check("rd_hold_req", {31'b0, avm_read}, 32'd1);
            check("rd_hold_addr", avm_address, prev_addr);
         end
         if (prev_wr_stall) begin
            check("wr_hold_req", {31'b0, avm_write}, 32'd1);
            check("wr_hold_addr", avm_address, prev_addr);
            check("wr_hold_data", {16'b0, avm_writedata}, {16'b0, prev_data});
         end
         if (avm_read && avm_write) flag("rd_wr_overlap", avm_address);

         wreq = rand_wait ? ($urandom_range(0, 1) == 1) : 1'b0;
         avm_waitrequest = wreq;

         if (stale_inject) begin
            avm_readdatavalid = 1'b1;
            avm_readdata      = 16'hDEAD;
            stale_inject      = 1'b0;
         end else if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
            r = rsp_q.pop_front();
            avm_readdatavalid = 1'b1;
            avm_readdata      = r.data;
            outstanding--;
         end else begin
            avm_readdatavalid = 1'b0;
            avm_readdata      = '0;
         end

         if (avm_read && !wreq) begin
            if (exp_rd_q.size() == 0) flag("unexpected_read", avm_address);
            else check("rd_addr", avm_address, exp_rd_q.pop_front());
            r.data = mem.exists(avm_address) ? mem[avm_address] : 16'hBAD0;
            due = cyc + $urandom_range(lat_min, lat_max);
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            r.due = due;
            rsp_q.push_back(r);
            outstanding++;
            check("outstanding_le16", {31'b0, outstanding <= 16}, 32'd1);
         end

         if (avm_write && !wreq) begin
            if (exp_wr_q.size() == 0) flag("unexpected_write", avm_address);
            else begin
               ew = exp_wr_q.pop_front();
               check("wr_addr", avm_address, ew.addr);
               check("wr_data", {16'b0, avm_writedata}, {16'b0, ew.data});
            end
            mem[avm_address] = avm_writedata;
         end

         prev_rd_stall = avm_read && wreq;
         prev_wr_stall = avm_write && wreq;
         prev_addr     = avm_address;
         prev_data     = avm_writedata;

         if (done && !done_prev) begin
            if (exp_ck_q.size() == 0) flag("unexpected_done", checksum);
            else check("checksum", checksum, exp_ck_q.pop_front());
            check("writes_left_at_done", exp_wr_q.size(), 32'd0);
         end
         done_prev = done;
      end
   end

   function automatic logic [31:0] sum_words(input logic [31:0] base, input int unsigned n);
      logic [31:0] s = '0;
      for (int i = 0; i < n; i++) s += 32'(mem[base + 32'(2 * i)]);
      return s;
   endfunction

   task automatic fill_words(input logic [31:0] base, input int unsigned n, input logic [15:0] seed);
      for (int i = 0; i < n; i++) mem[base + 32'(2 * i)] = seed + 16'(i * 16'h0101);
   endtask

   task automatic pulse_start(input logic [31:0] s, input logic [31:0] d, input logic [23:0] c);
      @(negedge clk);
      src_addr = s; dst_addr = d; word_count = c; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic start_job(input logic [31:0] s, input logic [31:0] d,
                            input int unsigned c, input logic [31:0] ck);
      wr_t ew;
      for (int i = 0; i < c; i++) begin
         exp_rd_q.push_back(s + 32'(2 * i));
         ew.addr = d + 32'(2 * i);
         ew.data = mem[s + 32'(2 * i)];
         exp_wr_q.push_back(ew);
      end
      exp_ck_q.push_back(ck);
      pulse_start(s, d, 24'(c));
   endtask

   task automatic wait_done(input string name, input int unsigned budget);
      int unsigned n = 0;
      while (!done && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(name, {31'b0, done}, 32'd1);
      @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      #1 reset = 1'b1;
      #2;
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_done", {31'b0, done}, 32'd0);
      check("rst_read", {31'b0, avm_read}, 32'd0);
      check("rst_write", {31'b0, avm_write}, 32'd0);
      check("rst_addr", avm_address, 32'd0);
      check("rst_wdata", {16'b0, avm_writedata}, 32'd0);
      check("rst_checksum", checksum, 32'd0);
      check("byteenable", {30'b0, avm_byteenable}, 32'd3);
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      // count = 0 from IDLE
      start_job(32'h4000, 32'h4800, 0, 32'h0);
      wait_done("zero_done", 2);

      // four words, 2-cycle latency, no stalls
      mem[32'h1000] = 16'h1234; mem[32'h1002] = 16'hABCD;
      mem[32'h1004] = 16'h0F0F; mem[32'h1006] = 16'h8001;
      start_job(32'h1000, 32'h8000, 4, 32'h0001_4D11);
      check("busy_after_start", {31'b0, busy}, 32'd1);
      wait_done("job4_done", 200);

      // 37 words: chunks 16/16/5, with an ignored start while busy
      lat_min = 3; lat_max = 3;
      fill_words(32'h2000, 37, 16'h1357);
      start_job(32'h2000, 32'h6000, 37, sum_words(32'h2000, 37));
      repeat (30) @(negedge clk);
      pulse_start(32'h7000, 32'h7800, 24'd3);
      check("busy_ignores_start", {31'b0, busy}, 32'd1);
      wait_done("job37_done", 2000);

      // random stalls + latency; start from DONE; carry into upper half
      rand_wait = 1'b1; lat_min = 1; lat_max = 8;
      fill_words(32'h2800, 3, 16'hFFFF);
      for (int i = 0; i < 3; i++) mem[32'h2800 + 32'(2 * i)] = 16'hFFFF;
      start_job(32'h2800, 32'hC000, 3, 32'h0002_FFFD);
      check("restart_done_drops", {31'b0, done}, 32'd0);
      check("restart_busy", {31'b0, busy}, 32'd1);
      wait_done("ffff_done", 500);

      fill_words(32'h3000, 18, 16'h8421);
      start_job(32'h3000, 32'hD000, 18, sum_words(32'h3000, 18));
      wait_done("rand18_done", 3000);

      // source address wraps past 2^32
      fill_words(32'hFFFF_FFFC, 2, 16'h00F0);
      fill_words(32'h0000_0000, 2, 16'h7E00);
      start_job(32'hFFFF_FFFC, 32'hE000, 4,
                sum_words(32'hFFFF_FFFC, 2) + sum_words(32'h0, 2));
      wait_done("wrap_done", 1000);

      // reset in the middle of WR
      rand_wait = 1'b0; lat_min = 2; lat_max = 2;
      fill_words(32'h3800, 20, 16'h0A0B);
      start_job(32'h3800, 32'h9000, 20, sum_words(32'h3800, 20));
      for (int n = 0; n < 200 && !avm_write; n++) @(negedge clk);
      check("reach_wr", {31'b0, avm_write}, 32'd1);
      @(negedge clk);
      @(posedge clk);
      #1 reset = 1'b1;
      #1;
      check("mid_rst_write", {31'b0, avm_write}, 32'd0);
      check("mid_rst_read", {31'b0, avm_read}, 32'd0);
      check("mid_rst_addr", avm_address, 32'd0);
      check("mid_rst_wdata", {16'b0, avm_writedata}, 32'd0);
      check("mid_rst_busy", {31'b0, busy}, 32'd0);
      check("mid_rst_checksum", checksum, 32'd0);
      exp_rd_q.delete();
      exp_wr_q.delete();
      exp_ck_q.delete();
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      stale_inject = 1'b1;
      repeat (4) @(negedge clk);
      check("stale_checksum", checksum, 32'd0);
      check("stale_busy", {31'b0, busy}, 32'd0);
      check("stale_done", {31'b0, done}, 32'd0);

      mem[32'h5000] = 16'h0102; mem[32'h5002] = 16'h0304;
      start_job(32'h5000, 32'hF000, 2, 32'h0000_0406);
      wait_done("post_rst_done", 200);

      // count = 0 from DONE: stays done, checksum cleared, no bus traffic
      pulse_start(32'h5000, 32'hF100, 24'd0);
      @(negedge clk);
      check("zero2_done", {31'b0, done}, 32'd1);
      check("zero2_busy", {31'b0, busy}, 32'd0);
      check("zero2_checksum", checksum, 32'd0);

      repeat (3) @(negedge clk);
      check("rd_queue_empty", exp_rd_q.size(), 32'd0);
      check("wr_queue_empty", exp_wr_q.size(), 32'd0);
      check("ck_queue_empty", exp_ck_q.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
